pixel_sensor_controller: RTL and testbench
==========================================

PIXEL_SENSOR_CONTROLLER -- requirements
Module: pixel_sensor_controller

Interface
REQ-001 SHALL have parameter PIXEL_BITS, default 8, conversion resolution; ramp length is 2^PIXEL_BITS pulses.
REQ-002 SHALL have parameter ERASE_CYCLES, default 5, cycles ERASE is held high (legal >=1).
REQ-003 SHALL have parameter EXPOSE_CYCLES, default 255, cycles EXPOSE is held high (legal >=1).
REQ-004 SHALL have parameter ROWS, default PIXEL_ARRAY_HEIGHT, number of rows read out per frame (legal >=1).
REQ-005 SHALL have parameter READ_CYCLES, default 2, cycles each row is selected (legal >=1).
REQ-006 SHALL have ports: clk in 1 system clock; reset in 1 synchronous active-high reset, the only clock and reset.
REQ-007 SHALL have ports: START in 1 frame request; ERASE out 1; EXPOSE out 1; RAMP out 1 ramp strobe to the analog pixels.
REQ-008 SHALL have ports: RAMP_CODE out PIXEL_BITS index of current ramp pulse; ROW_SELECT out $clog2(ROWS) row being read; READ out 1 row read enable.
REQ-009 SHALL have ports: BUSY out 1 high in any state except IDLE; FRAME_DONE out 1 single-cycle end-of-frame pulse.

Function
REQ-010 SHALL implement states IDLE, ERASE, EXPOSE, CONVERT, READ, all outputs registered (no combinational path input->output).
REQ-011 IDLE: START=1 -> ERASE next cycle; START=0 -> stay; START in any other state SHALL be ignored (no queuing).
REQ-012 ERASE state: ERASE=1 for exactly ERASE_CYCLES cycles, then EXPOSE.
REQ-013 EXPOSE state: EXPOSE=1 for exactly EXPOSE_CYCLES cycles, then CONVERT; ERASE and EXPOSE SHALL never be high together.
REQ-014 CONVERT: RAMP SHALL alternate 1,0 each cycle starting at 1, giving exactly 2^PIXEL_BITS rising edges over 2*2^PIXEL_BITS cycles, then READ.
REQ-015 RAMP_CODE SHALL equal k (0..2^PIXEL_BITS-1) during the high and following low cycle of the k-th pulse; 0 outside CONVERT; no wrap within a frame.
REQ-016 READ: ROW_SELECT steps 0..ROWS-1, each held READ_CYCLES cycles with READ=1; READ=0 outside READ state.
REQ-017 After last row's final cycle: FRAME_DONE=1 for one cycle concurrent with return to IDLE (BUSY=0 that cycle); next START accepted that same cycle's following edge.
REQ-018 Total frame latency START-sample to FRAME_DONE SHALL be 1+ERASE_CYCLES+EXPOSE_CYCLES+2*2^PIXEL_BITS+ROWS*READ_CYCLES cycles.
REQ-019 Phase counter SHALL be sized for the largest of ERASE_CYCLES, EXPOSE_CYCLES, 2*2^PIXEL_BITS, READ_CYCLES; no arithmetic overflow at maximum parameter values.
REQ-020 ROWS=1 SHALL produce ROW_SELECT=0 held READ_CYCLES cycles then FRAME_DONE.

Reset
REQ-021 reset=1 at any clock edge SHALL force IDLE regardless of state (including mid-CONVERT).
REQ-022 Reset values: ERASE=0, EXPOSE=0, RAMP=0, RAMP_CODE=0, ROW_SELECT=0, READ=0, BUSY=0, FRAME_DONE=0; all counters 0.
REQ-023 reset and START high together: reset wins; START SHALL be accepted only on a later cycle with reset=0.

Structure
REQ-024 State enum (IDLE..READ) and default timing constants SHALL live in PixelSensorConfig alongside PIXEL_BITS and PIXEL_ARRAY_HEIGHT.
REQ-025 Ramp-code generation SHALL reuse the existing Counter sub-module (bits=PIXEL_BITS) with enable gated by CONVERT and RAMP=1, clocked by clk.
REQ-026 Single always_ff for state/phase registers; no latches, no derived clocks.

Verification
REQ-027 Defaults, pulse START once -> ERASE high 5 cycles, EXPOSE high 255, 256 RAMP rises, READ high ROWS*2 cycles, FRAME_DONE at cycle 1+5+255+512+2*ROWS.
REQ-028 Controller driving PIXEL_SENSOR_ANALOG instances -> pixel with expose value V raises CMP during pulse with RAMP_CODE=V+1 edge; captured code matches scene.
REQ-029 START held high continuously -> frames back-to-back, one FRAME_DONE per frame, exactly one IDLE cycle between frames.
REQ-030 reset asserted at RAMP_CODE=100 -> next cycle all outputs at reset values; following START gives full frame with RAMP_CODE restarting at 0.
REQ-031 START pulsed during EXPOSE and READ -> ignored, frame timing unchanged, no extra frame.
REQ-032 PIXEL_BITS=4, ROWS=1, READ_CYCLES=1, ERASE_CYCLES=1, EXPOSE_CYCLES=1 -> 16 RAMP rises, FRAME_DONE 1+1+1+32+1=36 cycles after START.

Source files
------------

// File: rtl/pixel_sensor_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : PixelSensorConfig (package)
// Description : Shared configuration for the pixel sensor controller: default
//               timing constants, array geometry, controller state codes and
//               small constant helpers used to size counters.
// Revision    : 1.0 - initial release
// ============================================================================
package PixelSensorConfig;

  // Sensor geometry and default frame timing
  localparam int PIXEL_BITS_DEF     = 8;
  localparam int PIXEL_ARRAY_HEIGHT = 8;
  localparam int ERASE_CYCLES_DEF   = 5;
  localparam int EXPOSE_CYCLES_DEF  = 255;
  localparam int READ_CYCLES_DEF    = 2;

  // Controller state codes
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ERASE   = 3'd1;
  localparam logic [2:0] ST_EXPOSE  = 3'd2;
  localparam logic [2:0] ST_CONVERT = 3'd3;
  localparam logic [2:0] ST_READ    = 3'd4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold 0..n-1, never less than one bit
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_sensor_controller_counter.sv
`default_nettype none
// ============================================================================
// Module      : pixel_sensor_controller_counter
// Description : Generic up-counter with synchronous clear and enable; used by
//               the controller to produce the ramp code.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_sensor_controller_counter #(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr_i,
  input  logic            en_i,
  output logic [BITS-1:0] count_o
);

  logic [BITS-1:0] count_q;

  // Count enabled events; clear has priority over enable
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/pixel_sensor_controller.sv
`default_nettype none
// ============================================================================
// Module      : pixel_sensor_controller
// Description : Frame sequencer for an analog pixel array: erase, expose,
//               single-slope ramp conversion and row-by-row readout. All
//               outputs are registered decodes of the sequencer state, so each
//               visible phase trails the internal state by one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_sensor_controller
  import PixelSensorConfig::*;
#(
  parameter int PIXEL_BITS    = PIXEL_BITS_DEF,
  parameter int ERASE_CYCLES  = ERASE_CYCLES_DEF,
  parameter int EXPOSE_CYCLES = EXPOSE_CYCLES_DEF,
  parameter int ROWS          = PIXEL_ARRAY_HEIGHT,
  parameter int READ_CYCLES   = READ_CYCLES_DEF,
  localparam int ROW_W        = width_of(ROWS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  START,
  output logic                  ERASE,
  output logic                  EXPOSE,
  output logic                  RAMP,
  output logic [PIXEL_BITS-1:0] RAMP_CODE,
  output logic [ROW_W-1:0]      ROW_SELECT,
  output logic                  READ,
  output logic                  BUSY,
  output logic                  FRAME_DONE
);

  // One ramp pulse is a high cycle followed by a low cycle
  localparam int RAMP_CYCLES = 2 * (2 ** PIXEL_BITS);
  // One shared phase counter serves every timed state
  localparam int PHASE_MAX   = max_int(max_int(ERASE_CYCLES, EXPOSE_CYCLES),
                                       max_int(RAMP_CYCLES, READ_CYCLES));
  localparam int PHASE_W     = width_of(PHASE_MAX);

  localparam logic [PHASE_W-1:0] c_ERASE_LAST  = PHASE_W'(ERASE_CYCLES - 1);
  localparam logic [PHASE_W-1:0] c_EXPOSE_LAST = PHASE_W'(EXPOSE_CYCLES - 1);
  localparam logic [PHASE_W-1:0] c_RAMP_LAST   = PHASE_W'(RAMP_CYCLES - 1);
  localparam logic [PHASE_W-1:0] c_READ_LAST   = PHASE_W'(READ_CYCLES - 1);
  localparam logic [ROW_W-1:0]   c_ROW_LAST    = ROW_W'(ROWS - 1);

  logic [2:0]            state_q, state_d;
  logic [PHASE_W-1:0]    phase_q, phase_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic                  done_q, done_d;

  logic                  erase_q, expose_q, ramp_q, read_q, busy_q, frame_done_q;
  logic [PIXEL_BITS-1:0] ramp_code_q;
  logic [ROW_W-1:0]      row_sel_q;

  logic                  cnt_en, cnt_clr;
  logic [PIXEL_BITS-1:0] ramp_cnt;

  // Ramp code advances at the end of each pulse's high half as seen on RAMP
  assign cnt_en  = (state_q == ST_CONVERT) && ramp_q;
  assign cnt_clr = (state_q != ST_CONVERT);

  pixel_sensor_controller_counter #(
    .BITS (PIXEL_BITS)
  ) u_ramp_counter (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .count_o (ramp_cnt)
  );

  // Sequencer next-state: each timed state runs until its phase counter hits the last cycle
  always_comb begin
    state_d = state_q;
    phase_d = phase_q + 1'b1;
    row_d   = row_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        row_d   = '0;
        if (START) state_d = ST_ERASE;
      end
      ST_ERASE: begin
        if (phase_q == c_ERASE_LAST) begin
          state_d = ST_EXPOSE;
          phase_d = '0;
        end
      end
      ST_EXPOSE: begin
        if (phase_q == c_EXPOSE_LAST) begin
          state_d = ST_CONVERT;
          phase_d = '0;
        end
      end
      ST_CONVERT: begin
        if (phase_q == c_RAMP_LAST) begin
          state_d = ST_READ;
          phase_d = '0;
        end
      end
      ST_READ: begin
        if (phase_q == c_READ_LAST) begin
          phase_d = '0;
          if (row_q == c_ROW_LAST) begin
            state_d = ST_IDLE;
            row_d   = '0;
            done_d  = 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
        row_d   = '0;
      end
    endcase
  end

  // State, phase, row and end-of-frame marker registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

  // Registered output decode of the current state
  always_ff @(posedge clk) begin
    if (reset) begin
      erase_q      <= 1'b0;
      expose_q     <= 1'b0;
      ramp_q       <= 1'b0;
      ramp_code_q  <= '0;
      row_sel_q    <= '0;
      read_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      erase_q      <= (state_q == ST_ERASE);
      expose_q     <= (state_q == ST_EXPOSE);
      ramp_q       <= (state_q == ST_CONVERT) && !phase_q[0];
      ramp_code_q  <= (state_q == ST_CONVERT) ? ramp_cnt : '0;
      row_sel_q    <= (state_q == ST_READ) ? row_q : '0;
      read_q       <= (state_q == ST_READ);
      busy_q       <= (state_q != ST_IDLE);
      frame_done_q <= done_q;
    end
  end

  assign ERASE      = erase_q;
  assign EXPOSE     = expose_q;
  assign RAMP       = ramp_q;
  assign RAMP_CODE  = ramp_code_q;
  assign ROW_SELECT = row_sel_q;
  assign READ       = read_q;
  assign BUSY       = busy_q;
  assign FRAME_DONE = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_sensor_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_sensor_controller
// Description : Self-checking bench. Two controllers (default timing and a
//               minimal configuration) share START/reset; a timeline model
//               predicts every output from the edge at which each frame began.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_sensor_controller;

  localparam int A_PB = 8;
  localparam int A_E  = 5;
  localparam int A_X  = 255;
  localparam int A_R  = PixelSensorConfig::PIXEL_ARRAY_HEIGHT;
  localparam int A_RC = 2;
  localparam int B_PB = 4;
  localparam int B_E  = 1;
  localparam int B_X  = 1;
  localparam int B_R  = 1;
  localparam int B_RC = 1;

  logic clk = 1'b0;
  logic reset;
  logic START;

  logic       a_erase, a_expose, a_ramp, a_read, a_busy, a_done;
  logic [7:0] a_code;
  logic [2:0] a_row;
  logic       b_erase, b_expose, b_ramp, b_read, b_busy, b_done;
  logic [3:0] b_code;
  logic [0:0] b_row;

  always #5 clk = ~clk;

  pixel_sensor_controller u_dut_a (
    .clk        (clk),
    .reset      (reset),
    .START      (START),
    .ERASE      (a_erase),
    .EXPOSE     (a_expose),
    .RAMP       (a_ramp),
    .RAMP_CODE  (a_code),
    .ROW_SELECT (a_row),
    .READ       (a_read),
    .BUSY       (a_busy),
    .FRAME_DONE (a_done)
  );

  pixel_sensor_controller #(
    .PIXEL_BITS    (B_PB),
    .ERASE_CYCLES  (B_E),
    .EXPOSE_CYCLES (B_X),
    .ROWS          (B_R),
    .READ_CYCLES   (B_RC)
  ) u_dut_b (
    .clk        (clk),
    .reset      (reset),
    .START      (START),
    .ERASE      (b_erase),
    .EXPOSE     (b_expose),
    .RAMP       (b_ramp),
    .RAMP_CODE  (b_code),
    .ROW_SELECT (b_row),
    .READ       (b_read),
    .BUSY       (b_busy),
    .FRAME_DONE (b_done)
  );

  typedef struct {
    bit erase, expose, ramp, read, busy, done;
    int code, row;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  int   tnow   = 0;
  int   t0a    = -1;
  int   t0b    = -1;
  int   frames_a_exp = 0, frames_a_got = 0;
  int   frames_b_exp = 0, frames_b_got = 0;
  exp_t exp_a, exp_b;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0d: got %0d expected %0d", tag, tnow, got, exp);
    end
  endtask

  function automatic int frame_len(input int pb, input int e, input int x, input int r, input int rc);
    return 1 + e + x + 2 * (1 << pb) + r * rc;
  endfunction

  // Expected outputs k edges after the edge that accepted START
  function automatic exp_t model_out(input int pb, input int e, input int x, input int r,
                                     input int rc, input int t0, input int t);
    exp_t o;
    int   n2, l, k;
    o  = '{default: 0};
    if (t0 < 0) return o;
    n2 = 2 * (1 << pb);
    l  = frame_len(pb, e, x, r, rc);
    k  = t - t0;
    if (k >= 1 && k <= e) o.erase = 1'b1;
    else if (k > e && k <= e + x) o.expose = 1'b1;
    else if (k > e + x && k <= e + x + n2) begin
      o.ramp = ((k - 1 - e - x) % 2) == 0;
      o.code = (k - 1 - e - x) / 2;
    end else if (k > e + x + n2 && k < l) begin
      o.read = 1'b1;
      o.row  = (k - 1 - e - x - n2) / rc;
    end
    o.busy = (k >= 1) && (k < l);
    o.done = (k == l);
    return o;
  endfunction

  // One clock: drive inputs, advance the model at the edge, compare just after it
  task automatic tick(input bit st, input bit rs);
    @(negedge clk);
    START = st;
    reset = rs;
    @(posedge clk);
    tnow++;
    if (rs) begin
      t0a = -1;
      t0b = -1;
    end
    exp_a = model_out(A_PB, A_E, A_X, A_R, A_RC, t0a, tnow);
    exp_b = model_out(B_PB, B_E, B_X, B_R, B_RC, t0b, tnow);
    if (!rs && st) begin
      if (t0a < 0 || tnow - t0a >= frame_len(A_PB, A_E, A_X, A_R, A_RC)) t0a = tnow;
      if (t0b < 0 || tnow - t0b >= frame_len(B_PB, B_E, B_X, B_R, B_RC)) t0b = tnow;
    end
    if (exp_a.done) frames_a_exp++;
    if (exp_b.done) frames_b_exp++;
    #1;
    check_eq("a_erase",  32'(a_erase),  32'(exp_a.erase));
    check_eq("a_expose", 32'(a_expose), 32'(exp_a.expose));
    check_eq("a_ramp",   32'(a_ramp),   32'(exp_a.ramp));
    check_eq("a_code",   32'(a_code),   32'(exp_a.code));
    check_eq("a_row",    32'(a_row),    32'(exp_a.row));
    check_eq("a_read",   32'(a_read),   32'(exp_a.read));
    check_eq("a_busy",   32'(a_busy),   32'(exp_a.busy));
    check_eq("a_done",   32'(a_done),   32'(exp_a.done));
    check_eq("b_erase",  32'(b_erase),  32'(exp_b.erase));
    check_eq("b_expose", 32'(b_expose), 32'(exp_b.expose));
    check_eq("b_ramp",   32'(b_ramp),   32'(exp_b.ramp));
    check_eq("b_code",   32'(b_code),   32'(exp_b.code));
    check_eq("b_row",    32'(b_row),    32'(exp_b.row));
    check_eq("b_read",   32'(b_read),   32'(exp_b.read));
    check_eq("b_busy",   32'(b_busy),   32'(exp_b.busy));
    check_eq("b_done",   32'(b_done),   32'(exp_b.done));
    if (a_done) frames_a_got++;
    if (b_done) frames_b_got++;
  endtask

  initial begin
    int  ts, lat_a, lat_b, rises_a, rises_b, n_erase, n_expose, n_read;
    bit  prev_a, prev_b, hit;
    START = 1'b0;
    reset = 1'b1;

    // Reset held with START high: reset must win
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);

    // Single frame from one START pulse: latency and per-phase durations
    tick(1'b1, 1'b0);
    ts = tnow;
    lat_a = -1; lat_b = -1;
    rises_a = 0; rises_b = 0; n_erase = 0; n_expose = 0; n_read = 0;
    prev_a = 1'b0; prev_b = 1'b0;
    for (int i = 0; i < 1000 && lat_a < 0; i++) begin
      tick(1'b0, 1'b0);
      if (a_erase)  n_erase++;
      if (a_expose) n_expose++;
      if (a_read)   n_read++;
      if (a_ramp && !prev_a) rises_a++;
      if (b_ramp && !prev_b && lat_b < 0) rises_b++;
      prev_a = a_ramp;
      prev_b = b_ramp;
      if (b_done && lat_b < 0) lat_b = tnow - ts;
      if (a_done) lat_a = tnow - ts;
    end
    check_eq("a_latency",  32'(lat_a), 32'(1 + 5 + 255 + 512 + 2 * A_R));
    check_eq("b_latency",  32'(lat_b), 32'd36);
    check_eq("a_rises",    32'(rises_a), 32'd256);
    check_eq("b_rises",    32'(rises_b), 32'd16);
    check_eq("a_erase_n",  32'(n_erase), 32'd5);
    check_eq("a_expose_n", 32'(n_expose), 32'd255);
    check_eq("a_read_n",   32'(n_read), 32'(2 * A_R));

    // START held high: back-to-back frames
    for (int i = 0; i < 1700; i++) tick(1'b1, 1'b0);

    // Sparse random START pulses, rare random resets
    for (int i = 0; i < 2500; i++)
      tick($urandom_range(0, 39) == 0, $urandom_range(0, 2999) == 0);

    // Reset while RAMP_CODE shows 100, then a fresh full frame
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      if (exp_a.ramp && exp_a.code == 100) begin
        tick(1'b0, 1'b1);
        hit = 1'b1;
      end else begin
        tick(1'b0, 1'b0);
      end
    end
    check_eq("rst_at_code100", 32'(hit), 32'd1);
    tick(1'b1, 1'b0);
    for (int i = 0; i < 900; i++) tick(1'b0, 1'b0);

    // Random segments mixing held START and idle stretches
    for (int i = 0; i < 1500; i++)
      tick(($urandom_range(0, 3) == 0) ? 1'b1 : (i % 400 < 200), 1'b0);

    check_eq("a_frames", 32'(frames_a_got), 32'(frames_a_exp));
    check_eq("b_frames", 32'(frames_b_got), 32'(frames_b_exp));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
